// File: rtl/sin_meter_pkg.sv
// Shared defaults, FSM encoding and small helpers for the sin_meter receive path.
package sin_meter_pkg;

    localparam int NS_DEF   = 2048;
    localparam int HYST_DEF = 8;
    localparam int PW_DEF   = 10;

    typedef enum logic {
        SEARCH = 1'b0,
        MEAS   = 1'b1
    } state_t;

    function automatic logic [11:0] max12(input logic [11:0] a, input logic [11:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [11:0] min12(input logic [11:0] a, input logic [11:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/sin_meter_sign_hyst.sv
// Half-wave sign recovery with hysteresis around the mid-scale offset,
// plus the rising-crossing strobe and the saturated sample magnitude.
module sign_hyst
    import sin_meter_pkg::*;
#(
    parameter int NS   = NS_DEF,
    parameter int HYST = HYST_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic [11:0] DI,
    output logic        S,
    output logic        rise,
    output logic [11:0] mag
);

    localparam logic signed [12:0] NS_S   = 13'(NS);
    localparam logic signed [12:0] HYST_S = 13'(HYST);

    logic signed [12:0] dev;
    logic        [12:0] abs_dev;
    logic               pos;
    logic               neg;

    function automatic logic [11:0] sat12(input logic [12:0] v);
        return (v > 13'd4095) ? 12'hFFF : v[11:0];
    endfunction

    assign dev     = signed'({1'b0, DI}) - NS_S;
    assign abs_dev = dev[12] ? unsigned'(-dev) : unsigned'(dev);
    assign mag     = sat12(abs_dev);

    // Strictly outside the dead band; the band edges themselves leave S alone.
    assign pos  = (dev > HYST_S);
    assign neg  = (dev < -HYST_S);
    assign rise = ce & ~S & pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S <= 1'b0;
        end else if (ce) begin
            if (pos)
                S <= 1'b1;
            else if (neg)
                S <= 1'b0;
        end
    end

endmodule

// File: rtl/sin_meter.sv
// Period / amplitude meter for offset-binary sine samples.
// Optional raw extrema and offset outputs when SIN_MINMAX_EN is defined.
module sin_meter
    import sin_meter_pkg::*;
#(
    parameter int NS   = NS_DEF,
    parameter int HYST = HYST_DEF,
    parameter int PW   = PW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic [11:0]   DI,
    output logic          S,
    output logic [PW-1:0] PERIOD,
    output logic [11:0]   AMP,
    output logic          RDY,
    output logic          LOCK,
    output logic          ERR,
    output logic [11:0]   VMAX,
    output logic [11:0]   VMIN,
    output logic [11:0]   OFS
);

    localparam logic [PW-1:0] CNT_MAX = {PW{1'b1}};
    localparam logic [PW-1:0] CNT_ONE = PW'(1);

    logic          rise;
    logic [11:0]   mag;

    state_t        state, state_nx;
    logic [PW-1:0] cnt, cnt_nx;
    logic [11:0]   peak, peak_nx;
    logic [PW-1:0] period_nx;
    logic [11:0]   amp_nx;
    logic          rdy_nx, lock_nx, err_nx;
    logic [PW-1:0] diff;
    logic          near;

    sign_hyst #(
        .NS   (NS),
        .HYST (HYST)
    ) u_sign (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .DI    (DI),
        .S     (S),
        .rise  (rise),
        .mag   (mag)
    );

    assign diff = (cnt >= PERIOD) ? (cnt - PERIOD) : (PERIOD - cnt);
    assign near = (diff <= CNT_ONE);

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        peak_nx   = peak;
        period_nx = PERIOD;
        amp_nx    = AMP;
        rdy_nx    = 1'b0;
        err_nx    = 1'b0;
        lock_nx   = LOCK;
        if (ce) begin
            case (state)
                SEARCH: begin
                    cnt_nx  = '0;
                    peak_nx = '0;
                    if (rise) begin
                        state_nx = MEAS;
                        cnt_nx   = CNT_ONE;
                        peak_nx  = mag;
                    end
                end
                MEAS: begin
                    // A crossing on the last count still closes the period.
                    if (rise) begin
                        period_nx = cnt;
                        amp_nx    = max12(peak, mag);
                        rdy_nx    = 1'b1;
                        lock_nx   = near & (PERIOD != '0);
                        cnt_nx    = CNT_ONE;
                        peak_nx   = mag;
                    end else if (cnt == CNT_MAX) begin
                        state_nx  = SEARCH;
                        err_nx    = 1'b1;
                        lock_nx   = 1'b0;
                        period_nx = '0;
                        cnt_nx    = '0;
                        peak_nx   = '0;
                    end else begin
                        cnt_nx  = cnt + CNT_ONE;
                        peak_nx = max12(peak, mag);
                    end
                end
                default: state_nx = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= SEARCH;
            cnt    <= '0;
            peak   <= '0;
            PERIOD <= '0;
            AMP    <= '0;
            RDY    <= 1'b0;
            LOCK   <= 1'b0;
            ERR    <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            peak   <= peak_nx;
            PERIOD <= period_nx;
            AMP    <= amp_nx;
            RDY    <= rdy_nx;
            LOCK   <= lock_nx;
            ERR    <= err_nx;
        end
    end

`ifdef SIN_MINMAX_EN
    logic [11:0] run_max, run_min;
    logic [11:0] vmax_r, vmin_r;
    logic [12:0] ofs_sum;

    // Trackers restart on every crossing; results publish alongside RDY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_max <= '0;
            run_min <= '0;
            vmax_r  <= '0;
            vmin_r  <= '0;
        end else if (ce) begin
            if (rise) begin
                if (state == MEAS) begin
                    vmax_r <= max12(run_max, DI);
                    vmin_r <= min12(run_min, DI);
                end
                run_max <= DI;
                run_min <= DI;
            end else if (state == MEAS) begin
                run_max <= max12(run_max, DI);
                run_min <= min12(run_min, DI);
            end
        end
    end

    assign ofs_sum = {1'b0, vmax_r} + {1'b0, vmin_r};
    assign VMAX    = vmax_r;
    assign VMIN    = vmin_r;
    assign OFS     = ofs_sum[12:1];
`else
    assign VMAX = '0;
    assign VMIN = '0;
    assign OFS  = '0;
`endif

endmodule

// File: tb/tb_sin_meter.sv
// Directed self-checking bench for sin_meter (square waves, noise, timeout,
// magnitude extremes, period change, ce gaps, async reset).
module tb_sin_meter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic [11:0] DI;
    logic        S;
    logic [9:0]  PERIOD;
    logic [11:0] AMP;
    logic        RDY;
    logic        LOCK;
    logic        ERR;
    logic [11:0] VMAX, VMIN, OFS;

    int n_cmp = 0;
    int n_bad = 0;
    int rdy_seen = 0;
    int err_seen = 0;

    sin_meter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ce     (ce),
        .DI     (DI),
        .S      (S),
        .PERIOD (PERIOD),
        .AMP    (AMP),
        .RDY    (RDY),
        .LOCK   (LOCK),
        .ERR    (ERR),
        .VMAX   (VMAX),
        .VMIN   (VMIN),
        .OFS    (OFS)
    );

    always #5 clk = ~clk;

    // n ce samples of level d; with gap, an idle ce=0 clock follows each sample.
    task automatic drive(input logic [11:0] d, input int n, input bit gap = 1'b0);
        repeat (n) begin
            DI = d;
            ce = 1'b1;
            @(posedge clk);
            #1;
            if (RDY) rdy_seen++;
            if (ERR) err_seen++;
            if (gap) begin
                ce = 1'b0;
                @(posedge clk);
                #1;
                if (RDY) rdy_seen++;
                if (ERR) err_seen++;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ce    = 1'b0;
        DI    = 12'd2048;
        #13;
        n_cmp++;
        if ({S, PERIOD, AMP, RDY, LOCK, ERR, VMAX, VMIN, OFS} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got S=%b P=%0d A=%0d R=%b L=%b E=%b VMAX=%0d VMIN=%0d OFS=%0d expected all 0",
                     S, PERIOD, AMP, RDY, LOCK, ERR, VMAX, VMIN, OFS);
        end
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_square;
        drive(12'd3048, 1);
        n_cmp++;
        if (RDY !== 1'b0 || S !== 1'b1) begin
            n_bad++;
            $display("FAIL sq_first_rise: got RDY=%b S=%b expected RDY=0 S=1", RDY, S);
        end
        drive(12'd3048, 9);
        drive(12'd1048, 10);
        n_cmp++;
        if (S !== 1'b0) begin
            n_bad++;
            $display("FAIL sq_sign_low: got %b expected 0", S);
        end
        rdy_seen = 0;
        drive(12'd3048, 1);
        n_cmp++;
        if (RDY !== 1'b1 || PERIOD !== 10'd20 || AMP !== 12'd1000 || LOCK !== 1'b0) begin
            n_bad++;
            $display("FAIL sq_second_rise: got R=%b P=%0d A=%0d L=%b expected R=1 P=20 A=1000 L=0",
                     RDY, PERIOD, AMP, LOCK);
        end
        drive(12'd3048, 9);
        drive(12'd1048, 10);
        drive(12'd3048, 1);
        n_cmp++;
        if (RDY !== 1'b1 || PERIOD !== 10'd20 || AMP !== 12'd1000 || LOCK !== 1'b1) begin
            n_bad++;
            $display("FAIL sq_third_rise: got R=%b P=%0d A=%0d L=%b expected R=1 P=20 A=1000 L=1",
                     RDY, PERIOD, AMP, LOCK);
        end
        n_cmp++;
        if (rdy_seen !== 2) begin
            n_bad++;
            $display("FAIL sq_rdy_count: got %0d expected 2", rdy_seen);
        end
`ifdef SIN_MINMAX_EN
        n_cmp++;
        if (VMAX !== 12'd3048 || VMIN !== 12'd1048 || OFS !== 12'd2048) begin
            n_bad++;
            $display("FAIL sq_minmax: got %0d/%0d/%0d expected 3048/1048/2048", VMAX, VMIN, OFS);
        end
`else
        n_cmp++;
        if (VMAX !== 12'd0 || VMIN !== 12'd0 || OFS !== 12'd0) begin
            n_bad++;
            $display("FAIL sq_minmax_off: got %0d/%0d/%0d expected 0/0/0", VMAX, VMIN, OFS);
        end
`endif
    endtask

    task automatic test_period_change;
        drive(12'd3048, 11);
        drive(12'd1048, 12);
        drive(12'd3048, 1);
        n_cmp++;
        if (RDY !== 1'b1 || PERIOD !== 10'd24 || LOCK !== 1'b0) begin
            n_bad++;
            $display("FAIL chg_first: got R=%b P=%0d L=%b expected R=1 P=24 L=0", RDY, PERIOD, LOCK);
        end
        drive(12'd3048, 11);
        drive(12'd1048, 12);
        drive(12'd3048, 1);
        n_cmp++;
        if (RDY !== 1'b1 || PERIOD !== 10'd24 || LOCK !== 1'b1) begin
            n_bad++;
            $display("FAIL chg_second: got R=%b P=%0d L=%b expected R=1 P=24 L=1", RDY, PERIOD, LOCK);
        end
    endtask

    task automatic test_ce_gap;
        rdy_seen = 0;
        drive(12'd3048, 11, 1'b1);
        drive(12'd1048, 12, 1'b1);
        drive(12'd3048, 1);
        n_cmp++;
        if (RDY !== 1'b1 || PERIOD !== 10'd24 || LOCK !== 1'b1) begin
            n_bad++;
            $display("FAIL gap_rise: got R=%b P=%0d L=%b expected R=1 P=24 L=1", RDY, PERIOD, LOCK);
        end
        ce = 1'b0;
        DI = 12'd0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (RDY !== 1'b0 || S !== 1'b1 || PERIOD !== 10'd24) begin
            n_bad++;
            $display("FAIL gap_freeze: got R=%b S=%b P=%0d expected R=0 S=1 P=24", RDY, S, PERIOD);
        end
        n_cmp++;
        if (rdy_seen !== 1) begin
            n_bad++;
            $display("FAIL gap_rdy_count: got %0d expected 1", rdy_seen);
        end
    endtask

    task automatic test_noise;
        drive(12'd1048, 5);
        rdy_seen = 0;
        err_seen = 0;
        for (int i = 0; i < 20; i++) begin
            drive(12'd2050, 1);
            drive(12'd2046, 1);
            n_cmp++;
            if (S !== 1'b0) begin
                n_bad++;
                $display("FAIL noise_sign_%0d: got %b expected 0", i, S);
            end
        end
        drive(12'd2056, 1);
        n_cmp++;
        if (S !== 1'b0 || rdy_seen !== 0 || err_seen !== 0) begin
            n_bad++;
            $display("FAIL noise_band_hi: got S=%b rdy=%0d err=%0d expected 0/0/0", S, rdy_seen, err_seen);
        end
        drive(12'd2057, 1);
        n_cmp++;
        if (S !== 1'b1 || RDY !== 1'b1 || PERIOD !== 10'd47 || AMP !== 12'd1000 || LOCK !== 1'b0) begin
            n_bad++;
            $display("FAIL noise_cross: got S=%b R=%b P=%0d A=%0d L=%b expected S=1 R=1 P=47 A=1000 L=0",
                     S, RDY, PERIOD, AMP, LOCK);
        end
        drive(12'd2040, 3);
        n_cmp++;
        if (S !== 1'b1) begin
            n_bad++;
            $display("FAIL noise_band_lo: got %b expected 1", S);
        end
        drive(12'd2039, 1);
        n_cmp++;
        if (S !== 1'b0) begin
            n_bad++;
            $display("FAIL noise_below: got %b expected 0", S);
        end
    endtask

    task automatic test_timeout;
        drive(12'd2500, 1);
        n_cmp++;
        if (RDY !== 1'b1 || PERIOD !== 10'd5 || AMP !== 12'd452) begin
            n_bad++;
            $display("FAIL to_rise: got R=%b P=%0d A=%0d expected R=1 P=5 A=452", RDY, PERIOD, AMP);
        end
        err_seen = 0;
        rdy_seen = 0;
        drive(12'd2500, 1022);
        n_cmp++;
        if (err_seen !== 0) begin
            n_bad++;
            $display("FAIL to_early: got %0d ERR pulses expected 0", err_seen);
        end
        drive(12'd2500, 1);
        n_cmp++;
        if (ERR !== 1'b1 || LOCK !== 1'b0 || PERIOD !== 10'd0 || AMP !== 12'd452) begin
            n_bad++;
            $display("FAIL to_fire: got E=%b L=%b P=%0d A=%0d expected E=1 L=0 P=0 A=452", ERR, LOCK, PERIOD, AMP);
        end
        drive(12'd2500, 5);
        drive(12'd1048, 3);
        drive(12'd3048, 1);
        n_cmp++;
        if (err_seen !== 1 || rdy_seen !== 0 || RDY !== 1'b0) begin
            n_bad++;
            $display("FAIL to_search: got err=%0d rdy=%0d R=%b expected 1/0/0", err_seen, rdy_seen, RDY);
        end
    endtask

    task automatic test_extremes;
        drive(12'd4095, 4);
        drive(12'd0, 5);
        drive(12'd4095, 1);
        n_cmp++;
        if (RDY !== 1'b1 || PERIOD !== 10'd10 || AMP !== 12'd2048 || LOCK !== 1'b0) begin
            n_bad++;
            $display("FAIL ext_zero: got R=%b P=%0d A=%0d L=%b expected R=1 P=10 A=2048 L=0",
                     RDY, PERIOD, AMP, LOCK);
        end
`ifdef SIN_MINMAX_EN
        n_cmp++;
        if (VMAX !== 12'd4095 || VMIN !== 12'd0 || OFS !== 12'd2047) begin
            n_bad++;
            $display("FAIL ext_minmax_a: got %0d/%0d/%0d expected 4095/0/2047", VMAX, VMIN, OFS);
        end
`endif
        drive(12'd4095, 4);
        drive(12'd2000, 5);
        drive(12'd4095, 1);
        n_cmp++;
        if (RDY !== 1'b1 || PERIOD !== 10'd10 || AMP !== 12'd2047 || LOCK !== 1'b1) begin
            n_bad++;
            $display("FAIL ext_full: got R=%b P=%0d A=%0d L=%b expected R=1 P=10 A=2047 L=1",
                     RDY, PERIOD, AMP, LOCK);
        end
`ifdef SIN_MINMAX_EN
        n_cmp++;
        if (VMAX !== 12'd4095 || VMIN !== 12'd2000 || OFS !== 12'd3047) begin
            n_bad++;
            $display("FAIL ext_minmax_b: got %0d/%0d/%0d expected 4095/2000/3047", VMAX, VMIN, OFS);
        end
`endif
        err_seen = 0;
        drive(12'd4095, 500);
        drive(12'd2000, 522);
        drive(12'd4095, 1);
        n_cmp++;
        if (RDY !== 1'b1 || ERR !== 1'b0 || err_seen !== 0 || PERIOD !== 10'd1023 || LOCK !== 1'b0) begin
            n_bad++;
            $display("FAIL ext_max_count: got R=%b E=%b err=%0d P=%0d L=%b expected R=1 E=0 err=0 P=1023 L=0",
                     RDY, ERR, err_seen, PERIOD, LOCK);
        end
    endtask

    task automatic test_async_reset;
        drive(12'd4095, 5);
        #3 rst_n = 1'b0;
        ce = 1'b0;
        #1;
        n_cmp++;
        if ({S, PERIOD, AMP, RDY, LOCK, ERR, VMAX, VMIN, OFS} !== '0) begin
            n_bad++;
            $display("FAIL arst_clear: got S=%b P=%0d A=%0d R=%b L=%b E=%b VMAX=%0d expected all 0",
                     S, PERIOD, AMP, RDY, LOCK, ERR, VMAX);
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        rdy_seen = 0;
        drive(12'd3048, 10);
        drive(12'd1048, 10);
        drive(12'd3048, 1);
        n_cmp++;
        if (rdy_seen !== 1 || RDY !== 1'b1 || PERIOD !== 10'd20 || AMP !== 12'd1000 || LOCK !== 1'b0) begin
            n_bad++;
            $display("FAIL arst_restart: got rdy=%0d R=%b P=%0d A=%0d L=%b expected 1/1/20/1000/0",
                     rdy_seen, RDY, PERIOD, AMP, LOCK);
        end
`ifdef SIN_MINMAX_EN
        n_cmp++;
        if (VMAX !== 12'd3048 || VMIN !== 12'd1048 || OFS !== 12'd2048) begin
            n_bad++;
            $display("FAIL arst_minmax: got %0d/%0d/%0d expected 3048/1048/2048", VMAX, VMIN, OFS);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_square();
        test_period_change();
        test_ce_gap();
        test_noise();
        test_timeout();
        test_extremes();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
